// File: rtl/stack_engine.sv
// Hardware stack unit: owns the stack pointer and sequences PUSH/POP/PEEK to data memory
// over a req/ack handshake, with depth tracking, overflow/underflow errors and a memory timeout.
module stack_engine #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 26,
  parameter logic [ADDR_WIDTH-1:0] INIT_SP     = {ADDR_WIDTH{1'b1}},
  parameter int                    STACK_DEPTH = 1024,
  parameter int                    MEM_TIMEOUT = 16
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               CMD_VALID,
  output logic                               CMD_READY,
  input  logic [1:0]                         CMD_OP,
  input  logic [DATA_WIDTH-1:0]              CMD_DATA,
  output logic                               RSP_VALID,
  output logic [DATA_WIDTH-1:0]              RSP_DATA,
  output logic                               RSP_ERR,
  output logic [ADDR_WIDTH-1:0]              SP,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   COUNT,
  output logic                               FULL,
  output logic                               EMPTY,
  output logic                               MEM_REQ,
  output logic                               MEM_WE,
  output logic [ADDR_WIDTH-1:0]              MEM_ADDR,
  output logic [DATA_WIDTH-1:0]              MEM_WDATA,
  input  logic [DATA_WIDTH-1:0]              MEM_RDATA,
  input  logic                               MEM_ACK
);
  localparam int CW    = $clog2(STACK_DEPTH + 1);
  localparam int TW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TLAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] sp_reg;
  logic [CW-1:0]         count_reg;
  logic [1:0]            op_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [TW-1:0]         timer_reg;

  logic full, empty, accept_ok, timed_out;

  assign full      = (count_reg == CW'(STACK_DEPTH));
  assign empty     = (count_reg == '0);
  assign timed_out = (MEM_TIMEOUT > 0) && (timer_reg == TW'(TLAST));

  always_comb begin
    accept_ok = 1'b0;
    case (CMD_OP)
      OP_PUSH:         accept_ok = !full;
      OP_POP, OP_PEEK: accept_ok = !empty;
      default:         accept_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (CMD_VALID) state_next = accept_ok ? S_MEM : S_RESP;
      S_MEM:   if (MEM_ACK || timed_out) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    CMD_READY = (state_reg == S_IDLE);
    MEM_REQ   = (state_reg == S_MEM);
    RSP_VALID = (state_reg == S_RESP);
    RSP_ERR   = (state_reg == S_RESP) && err_reg;
  end

  // Datapath: memory request fields latch at accept; SP/COUNT/RSP_DATA move only on ACK.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sp_reg        <= INIT_SP;
      count_reg     <= '0;
      op_reg        <= 2'b00;
      err_reg       <= 1'b0;
      rsp_data_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      timer_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (CMD_VALID) begin
            op_reg    <= CMD_OP;
            timer_reg <= '0;
            err_reg   <= !accept_ok;
            if (accept_ok) begin
              mem_we_reg <= (CMD_OP == OP_PUSH);
              if (CMD_OP == OP_PUSH) begin
                mem_addr_reg  <= sp_reg;
                mem_wdata_reg <= CMD_DATA;
              end else begin
                mem_addr_reg  <= sp_reg + ADDR_WIDTH'(1);
              end
            end
          end
        end
        S_MEM: begin
          if (MEM_ACK) begin
            err_reg <= 1'b0;
            case (op_reg)
              OP_PUSH: begin
                sp_reg    <= sp_reg - ADDR_WIDTH'(1);
                count_reg <= count_reg + CW'(1);
              end
              OP_POP: begin
                rsp_data_reg <= MEM_RDATA;
                sp_reg       <= sp_reg + ADDR_WIDTH'(1);
                count_reg    <= count_reg - CW'(1);
              end
              OP_PEEK: rsp_data_reg <= MEM_RDATA;
              default: err_reg <= 1'b1;
            endcase
          end else if (timed_out) begin
            err_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign SP        = sp_reg;
  assign COUNT     = count_reg;
  assign FULL      = full;
  assign EMPTY     = empty;
  assign MEM_WE    = mem_we_reg;
  assign MEM_ADDR  = mem_addr_reg;
  assign MEM_WDATA = mem_wdata_reg;
  assign RSP_DATA  = rsp_data_reg;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: directed vector table, mid-operation reset, then random commands
// checked against a queue-based stack model and a bench-side memory.
module tb_stack_engine;
  localparam int          DEPTH   = 4;
  localparam int          TMO     = 16;
  localparam logic [25:0] INIT_SP = 26'h3FFFFFF;
  localparam logic [1:0]  RSV = 2'b00, PUSH = 2'b01, POP = 2'b10, PEEK = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [25:0] sp;
  logic [2:0]  count;
  logic        full, empty;
  logic        mem_req, mem_we;
  logic [25:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  stack_engine #(.STACK_DEPTH(DEPTH), .MEM_TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op), .CMD_DATA(cmd_data),
    .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
    .SP(sp), .COUNT(count), .FULL(full), .EMPTY(empty),
    .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] mem [logic [25:0]];
  logic [31:0] q [$];
  logic [31:0] model_rsp = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          waits;
    bit          never_ack;
    bit          exp_err;
    logic [31:0] exp_data;
    logic [25:0] exp_sp;
    int          exp_cnt;
    int          exp_lat;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one command, act as memory with the given wait states, check response and state.
  task automatic do_cmd(input string name, input logic [1:0] op, input logic [31:0] data,
                        input int waits, input bit never_ack, input bit exp_err,
                        input logic [31:0] exp_data, input logic [25:0] exp_sp,
                        input int exp_cnt, input int exp_lat, input logic [25:0] exp_addr);
    int  reqs = 0;
    int  lat  = 0;
    bit  done = 0;
    check({name, ".ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = $urandom;
    for (int k = 0; k < 40 && !done; k++) begin
      if (rsp_valid) begin
        lat  = k + 1;
        done = 1;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) begin
          check({name, ".addr"}, mem_addr, exp_addr);
          check({name, ".we"}, mem_we, (op == PUSH));
          if (op == PUSH) check({name, ".wdata"}, mem_wdata, data);
          if (!never_ack && reqs == waits) begin
            mem_ack = 1'b1;
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hBAD0BAD0;
          end
          reqs++;
        end
        @(posedge clk); #1;
      end
    end
    mem_ack = 1'b0;
    check({name, ".latency"}, lat, exp_lat);
    check({name, ".req_cycles"}, reqs, exp_lat - 1);
    if (done) begin
      check({name, ".err"}, rsp_err, exp_err);
      check({name, ".rsp_data"}, rsp_data, exp_data);
    end
    @(posedge clk); #1;
    check({name, ".pulse"}, rsp_valid, 0);
    check({name, ".sp"}, sp, exp_sp);
    check({name, ".count"}, count, exp_cnt);
    check({name, ".full"}, full, (exp_cnt == DEPTH));
    check({name, ".empty"}, empty, (exp_cnt == 0));
    $display("txn %s op=%0d data=%h waits=%0d lat=%0d err=%0b rsp=%h sp=%h cnt=%0d",
             name, op, data, never_ack ? -1 : waits, lat, rsp_err, rsp_data, sp, count);
  endtask

  // Reference model: stack as a queue, SP derived from its size.
  task automatic run_model(input string name, input logic [1:0] op, input logic [31:0] data,
                           input int waits, input bit never_ack);
    int          sz  = q.size();
    bit          tmo = never_ack || (waits >= TMO);
    bit          err;
    int          lat;
    logic [25:0] addr;
    addr = (op == PUSH) ? 26'(INIT_SP - sz) : 26'(INIT_SP - sz + 1);
    if (op == RSV || (op == PUSH && sz == DEPTH) || (op != PUSH && sz == 0)) begin
      err = 1; lat = 1;
    end else if (tmo) begin
      err = 1; lat = TMO + 1;
    end else begin
      err = 0; lat = waits + 2;
      case (op)
        PUSH:    q.push_back(data);
        POP:     model_rsp = q.pop_back();
        default: model_rsp = q[$];
      endcase
    end
    do_cmd(name, op, data, waits, never_ack, err, model_rsp, 26'(INIT_SP - q.size()),
           q.size(), lat, addr);
  endtask

  initial begin
    logic [25:0] cur_sp;
    vecs[0]  = '{PUSH, 32'hDEADBEEF, 0, 0, 0, 32'h00000000, 26'h3FFFFFE, 1, 2};
    vecs[1]  = '{POP,  32'h0,        0, 0, 0, 32'hDEADBEEF, 26'h3FFFFFF, 0, 2};
    vecs[2]  = '{POP,  32'h0,        0, 0, 1, 32'hDEADBEEF, 26'h3FFFFFF, 0, 1};
    vecs[3]  = '{PEEK, 32'h0,        0, 0, 1, 32'hDEADBEEF, 26'h3FFFFFF, 0, 1};
    vecs[4]  = '{RSV,  32'h12345678, 0, 0, 1, 32'hDEADBEEF, 26'h3FFFFFF, 0, 1};
    vecs[5]  = '{PUSH, 32'h11111111, 2, 0, 0, 32'hDEADBEEF, 26'h3FFFFFE, 1, 4};
    vecs[6]  = '{PUSH, 32'h22222222, 2, 0, 0, 32'hDEADBEEF, 26'h3FFFFFD, 2, 4};
    vecs[7]  = '{PUSH, 32'h33333333, 2, 0, 0, 32'hDEADBEEF, 26'h3FFFFFC, 3, 4};
    vecs[8]  = '{POP,  32'h0,        2, 0, 0, 32'h33333333, 26'h3FFFFFD, 2, 4};
    vecs[9]  = '{POP,  32'h0,        2, 0, 0, 32'h22222222, 26'h3FFFFFE, 1, 4};
    vecs[10] = '{POP,  32'h0,        2, 0, 0, 32'h11111111, 26'h3FFFFFF, 0, 4};
    vecs[11] = '{PUSH, 32'hA0000001, 0, 0, 0, 32'h11111111, 26'h3FFFFFE, 1, 2};
    vecs[12] = '{PUSH, 32'hA0000002, 1, 0, 0, 32'h11111111, 26'h3FFFFFD, 2, 3};
    vecs[13] = '{PUSH, 32'hA0000003, 0, 0, 0, 32'h11111111, 26'h3FFFFFC, 3, 2};
    vecs[14] = '{PUSH, 32'hA0000004, 1, 0, 0, 32'h11111111, 26'h3FFFFFB, 4, 3};
    vecs[15] = '{PUSH, 32'hA0000005, 0, 0, 1, 32'h11111111, 26'h3FFFFFB, 4, 1};
    vecs[16] = '{PEEK, 32'h0,        1, 0, 0, 32'hA0000004, 26'h3FFFFFB, 4, 3};
    vecs[17] = '{POP,  32'h0,        0, 0, 0, 32'hA0000004, 26'h3FFFFFC, 3, 2};
    vecs[18] = '{PUSH, 32'hC0FFEE00, 0, 1, 1, 32'hA0000004, 26'h3FFFFFC, 3, 17};
    vecs[19] = '{PUSH, 32'hC0FFEE01, 15, 0, 0, 32'hA0000004, 26'h3FFFFFB, 4, 17};
    vecs[20] = '{POP,  32'h0,        0, 0, 0, 32'hC0FFEE01, 26'h3FFFFFC, 3, 2};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.sp", sp, INIT_SP);
    check("rst.count", count, 0);
    check("rst.empty", empty, 1);
    check("rst.full", full, 0);
    check("rst.ready", cmd_ready, 1);
    check("rst.mem_req", mem_req, 0);
    check("rst.mem_we", mem_we, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.mem_wdata", mem_wdata, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_err", rsp_err, 0);
    check("rst.rsp_data", rsp_data, 0);
    rst = 1'b1;

    cur_sp = INIT_SP;
    for (int i = 0; i < 21; i++) begin
      do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].waits, vecs[i].never_ack,
             vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_sp, vecs[i].exp_cnt, vecs[i].exp_lat,
             (vecs[i].op == PUSH) ? cur_sp : cur_sp + 26'd1);
      cur_sp = vecs[i].exp_sp;
    end

    // Reset while a POP is stalled waiting for ACK.
    check("midrst.ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = POP;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midrst.req%0d", k), mem_req, 1);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst.mem_req", mem_req, 0);
    check("midrst.sp", sp, INIT_SP);
    check("midrst.count", count, 0);
    check("midrst.rsp_valid", rsp_valid, 0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_ack = 1'b1;
      check($sformatf("midrst.no_rsp%0d", k), rsp_valid, 0);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    $display("txn midrst pop aborted by reset sp=%h cnt=%0d", sp, count);
    q.delete();
    model_rsp = '0;
    run_model("after_rst_push", PUSH, 32'h5A5A5A5A, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int          r     = $urandom_range(0, 9);
      int          w     = $urandom_range(0, 3);
      bit          na    = 0;
      int          sel   = $urandom_range(0, 11);
      logic [1:0]  op;
      op = (r == 0) ? RSV : (r <= 4) ? PUSH : (r <= 7) ? POP : PEEK;
      if (sel == 0) na = 1;
      else if (sel == 1) w = 15;
      run_model($sformatf("rnd%0d", i), op, $urandom, w, na);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
